// File: rtl/pg_carry_pipe.sv
// Two-stage pipelined carry-lookahead sum stage: S1 registers p/g/cin plus group P/G,
// S2 resolves group and bit carries into a registered sum. Optional ovf port: PG_CARRY_OVF_EN.
module pg_carry_pipe #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] p_in,
  input  logic [WIDTH-1:0] g_in,
  input  logic             c_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             out_valid,
  input  logic             out_ready
`ifdef PG_CARRY_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NG = WIDTH / GROUP;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_p_q, s1_p_d;
  logic [WIDTH-1:0] s1_g_q, s1_g_d;
  logic             s1_c_q, s1_c_d;
  logic [NG-1:0]    s1_gp_q, s1_gp_d;
  logic [NG-1:0]    s1_gg_q, s1_gg_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
`ifdef PG_CARRY_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             s2_adv;
  logic             s1_adv;
  logic [NG-1:0]    grp_p;
  logic [NG-1:0]    grp_g;
  logic             gp_run;
  logic             gg_run;
  logic [NG:0]      grp_c;
  logic [WIDTH:0]   carry;
  logic             c_run;
  logic             b_run;

  // Valid/ready: a side transfers on a clock edge where its valid and ready are both
  // high. in_ready never looks at in_valid, so no combinational loop with the producer.
  assign s2_adv   = !out_valid_q | out_ready;
  assign s1_adv   = s1_valid_q & s2_adv;
  assign in_ready = rst_n & (!s1_valid_q | s2_adv);

  // Group propagate/generate in the classic lookahead form, from the raw inputs.
  always_comb begin
    grp_p  = '0;
    grp_g  = '0;
    gp_run = 1'b1;
    gg_run = 1'b0;
    for (int k = 0; k < NG; k++) begin
      gp_run = 1'b1;
      gg_run = 1'b0;
      for (int j = 0; j < GROUP; j++) begin
        gp_run = gp_run & p_in[k*GROUP+j];
        gg_run = g_in[k*GROUP+j] | (p_in[k*GROUP+j] & gg_run);
      end
      grp_p[k] = gp_run;
      grp_g[k] = gg_run;
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_p_d     = s1_p_q;
    s1_g_d     = s1_g_q;
    s1_c_d     = s1_c_q;
    s1_gp_d    = s1_gp_q;
    s1_gg_d    = s1_gg_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_p_d  = p_in;
        s1_g_d  = g_in;
        s1_c_d  = c_in;
        s1_gp_d = grp_p;
        s1_gg_d = grp_g;
      end
    end
  end

  // Group carries first, then each group's bit carries seeded from its group carry.
  always_comb begin
    grp_c = '0;
    carry = '0;
    c_run = s1_c_q;
    b_run = 1'b0;
    for (int k = 0; k < NG; k++) begin
      grp_c[k] = c_run;
      c_run    = s1_gg_q[k] | (s1_gp_q[k] & c_run);
    end
    grp_c[NG] = c_run;
    for (int k = 0; k < NG; k++) begin
      b_run = grp_c[k];
      for (int j = 0; j < GROUP; j++) begin
        carry[k*GROUP+j] = b_run;
        b_run = s1_g_q[k*GROUP+j] | (s1_p_q[k*GROUP+j] & b_run);
      end
    end
    carry[WIDTH] = grp_c[NG];
  end

  always_comb begin
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    c_out_d     = c_out_q;
`ifdef PG_CARRY_OVF_EN
    ovf_d       = ovf_q;
`endif
    if (s2_adv) out_valid_d = s1_valid_q;
    if (s1_adv) begin
      sum_d   = s1_p_q ^ carry[WIDTH-1:0];
      c_out_d = carry[WIDTH];
`ifdef PG_CARRY_OVF_EN
      ovf_d   = carry[WIDTH] ^ carry[WIDTH-1];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_p_q      <= '0;
      s1_g_q      <= '0;
      s1_c_q      <= 1'b0;
      s1_gp_q     <= '0;
      s1_gg_q     <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      c_out_q     <= 1'b0;
`ifdef PG_CARRY_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_p_q      <= s1_p_d;
      s1_g_q      <= s1_g_d;
      s1_c_q      <= s1_c_d;
      s1_gp_q     <= s1_gp_d;
      s1_gg_q     <= s1_gg_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      c_out_q     <= c_out_d;
`ifdef PG_CARRY_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
`ifdef PG_CARRY_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
